// File: rtl/shift_seq_arb.sv
// shift_seq_arb: two-requester round-robin front end that sequences 16-bit
// SLL / SRA / ROR operations through one external shared shift unit.
// ROR by n (n != 0) takes two passes through the shift unit: SLL by (16-n),
// then SRA by n with the sign-extended high bits masked off.
//
// Handshake: reqN_ready is offered only in IDLE, to at most one requester,
// and only while that requester's valid is high. A transfer happens on a
// rising edge where reqN_valid && reqN_ready. The response side has no
// backpressure: rsp_valid is a single-cycle pulse.

`timescale 1ns/1ps

module shift_seq_arb (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [15:0] req0_data,
  input  logic [15:0] req1_data,
  input  logic [3:0]  req0_amt,
  input  logic [3:0]  req1_amt,
  input  logic [1:0]  req0_op,
  input  logic [1:0]  req1_op,
  output logic [15:0] sh_in,
  output logic [3:0]  sh_val,
  output logic        sh_mode,
  input  logic [15:0] sh_out,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EXEC1 = 2'd1,
    EXEC2 = 2'd2,
    RSP   = 2'd3
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t      state_q, state_d;
  logic        ptr_q, ptr_d;        // 0: req0 favoured on a tie, 1: req1
  logic [15:0] data_q, data_d;
  logic [3:0]  amt_q, amt_d;
  logic [1:0]  op_q, op_d;
  logic        id_q, id_d;
  logic [15:0] tmp_q, tmp_d;
  logic [15:0] sh_in_q, sh_in_d;
  logic [3:0]  sh_val_q, sh_val_d;
  logic        sh_mode_q, sh_mode_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic        grant0, grant1;
  logic        hs0, hs1;
  logic        sel;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic [1:0]  in_op;

  // Round-robin grant: a lone valid wins; on a tie the pointer decides.
  always_comb begin
    grant0     = req0_valid && (!req1_valid || !ptr_q);
    grant1     = req1_valid && (!req0_valid ||  ptr_q);
    req0_ready = rst_n && (state_q == IDLE) && grant0;
    req1_ready = rst_n && (state_q == IDLE) && grant1;
    hs0        = req0_valid && req0_ready;
    hs1        = req1_valid && req1_ready;
    sel        = hs1;
    in_data    = sel ? req1_data : req0_data;
    in_amt     = sel ? req1_amt  : req0_amt;
    in_op      = sel ? req1_op   : req0_op;
  end

  // Next-state and next-output logic; shift-unit controls are set up one
  // cycle ahead so they are stable from flops during EXEC1 / EXEC2.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    amt_d       = amt_q;
    op_d        = op_q;
    id_d        = id_q;
    tmp_d       = tmp_q;
    sh_in_d     = 16'h0000;
    sh_val_d    = 4'd0;
    sh_mode_d   = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (hs0 || hs1) begin
          data_d  = in_data;
          amt_d   = in_amt;
          op_d    = in_op;
          id_d    = sel;
          ptr_d   = !sel;
          state_d = EXEC1;
          sh_in_d = in_data;
          case (in_op)
            OP_SLL: begin
              sh_val_d  = in_amt;
              sh_mode_d = 1'b0;
            end
            OP_SRA: begin
              sh_val_d  = in_amt;
              sh_mode_d = 1'b1;
            end
            OP_ROR: begin
              // First pass of a rotate: SLL by (16-n); n=0 is a plain pass-through.
              sh_val_d  = (in_amt == 4'd0) ? 4'd0 : 4'(5'd16 - {1'b0, in_amt});
              sh_mode_d = 1'b0;
            end
            default: begin
              sh_val_d  = 4'd0;
              sh_mode_d = 1'b0;
            end
          endcase
        end
      end
      EXEC1: begin
        if ((op_q == OP_ROR) && (amt_q != 4'd0)) begin
          tmp_d     = sh_out;
          sh_in_d   = data_q;
          sh_val_d  = amt_q;
          sh_mode_d = 1'b1;
          state_d   = EXEC2;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_id_d    = id_q;
          rsp_data_d  = sh_out;
          rsp_err_d   = (op_q == OP_RSV);
          state_d     = RSP;
        end
      end
      EXEC2: begin
        // SRA sign-fills the top n bits; keep only the low (16-n) bits.
        rsp_valid_d = 1'b1;
        rsp_id_d    = id_q;
        rsp_data_d  = (sh_out & (16'hFFFF >> amt_q)) | tmp_q;
        rsp_err_d   = 1'b0;
        state_d     = RSP;
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Single state/output register bank with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      data_q      <= 16'h0000;
      amt_q       <= 4'd0;
      op_q        <= OP_SLL;
      id_q        <= 1'b0;
      tmp_q       <= 16'h0000;
      sh_in_q     <= 16'h0000;
      sh_val_q    <= 4'd0;
      sh_mode_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= 16'h0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      amt_q       <= amt_d;
      op_q        <= op_d;
      id_q        <= id_d;
      tmp_q       <= tmp_d;
      sh_in_q     <= sh_in_d;
      sh_val_q    <= sh_val_d;
      sh_mode_q   <= sh_mode_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign sh_in     = sh_in_q;
  assign sh_val    = sh_val_q;
  assign sh_mode   = sh_mode_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_seq_arb.sv
// Directed testbench for shift_seq_arb with a behavioural shared shift unit.

`timescale 1ns/1ps

module tb_shift_seq_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [15:0] req0_data, req1_data;
  logic [3:0]  req0_amt, req1_amt;
  logic [1:0]  req0_op, req1_op;
  logic [15:0] sh_in;
  logic [3:0]  sh_val;
  logic        sh_mode;
  logic [15:0] sh_out;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic        dual_seen = 1'b0;
  logic [3:0]  rec_val  [1:8];
  logic        rec_mode [1:8];
  logic [15:0] rec_in   [1:8];
  logic [15:0] exp_q [$];

  shift_seq_arb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_data  (req0_data),
    .req1_data  (req1_data),
    .req0_amt   (req0_amt),
    .req1_amt   (req1_amt),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .sh_in      (sh_in),
    .sh_val     (sh_val),
    .sh_mode    (sh_mode),
    .sh_out     (sh_out),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .dbg_state  (dbg_state)
  );

  // Clock and reference shift unit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (sh_mode) sh_out = 16'($signed(sh_in) >>> sh_val);
    else         sh_out = sh_in << sh_val;
  end

  always @(negedge clk) begin
    #2;
    if (req0_ready && req1_ready) dual_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = 16'($urandom);
    req1_data  = 16'($urandom);
    req0_amt   = 4'($urandom_range(0, 15));
    req1_amt   = 4'($urandom_range(0, 15));
    req0_op    = 2'($urandom_range(0, 3));
    req1_op    = 2'($urandom_range(0, 3));
  endtask

  // Drive one request and return just after its handshake edge.
  task automatic issue(input logic id, input logic [1:0] op, input logic [3:0] amt,
                       input logic [15:0] data);
    bit done = 0;
    @(negedge clk);
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_amt = amt; req1_data = data;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_amt = amt; req0_data = data;
    end
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (id ? req1_ready : req0_ready) begin
        @(posedge clk);
        done = 1;
      end else begin
        @(negedge clk);
      end
    end
    #1;
    scramble();
    if (!done) check("handshake_timeout", 0, 1);
  endtask

  // Wait for the response, recording shift-unit drive in each cycle.
  task automatic wait_rsp(input string tag, input int exp_lat, input logic exp_id,
                          input logic [15:0] exp_data, input logic exp_err);
    int lat = 0;
    bit got = 0;
    logic [15:0] held;
    exp_q.push_back(exp_data);
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      rec_val[c]  = sh_val;
      rec_mode[c] = sh_mode;
      rec_in[c]   = sh_in;
      if (rsp_valid) begin
        got = 1;
        lat = c;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (got) begin
      check({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
      check({tag, "_data"}, 32'(rsp_data), 32'(exp_q.pop_front()));
      check({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, "_sh_idle"}, {12'd0, rec_val[lat], rec_in[lat]}, 32'd0);
      held = rsp_data;
      @(negedge clk);
      check({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
      check({tag, "_hold"}, 32'(rsp_data), 32'(held));
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int g[4];
    int ng;
    bit bad;

    rst_n = 1'b0;
    scramble();
    req0_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 32'd0);
    check("rst_sh", {sh_mode, sh_val, sh_in}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 2'b00, 4'd4, 16'h00F1);
    wait_rsp("sll", 2, 0, 16'h0F10, 0);
    check("sll_ex1", {rec_mode[1], rec_val[1], rec_in[1]}, {1'b0, 4'd4, 16'h00F1});

    issue(1, 2'b01, 4'd15, 16'h8000);
    wait_rsp("sra", 2, 1, 16'hFFFF, 0);

    issue(0, 2'b10, 4'd4, 16'h1234);
    wait_rsp("ror4", 3, 0, 16'h4123, 0);
    check("ror4_ex1", {rec_mode[1], rec_val[1], rec_in[1]}, {1'b0, 4'd12, 16'h1234});
    check("ror4_ex2", {rec_mode[2], rec_val[2], rec_in[2]}, {1'b1, 4'd4, 16'h1234});

    issue(1, 2'b10, 4'd1, 16'h8001);
    wait_rsp("ror1", 3, 1, 16'hC000, 0);

    issue(0, 2'b10, 4'd0, 16'hABCD);
    wait_rsp("ror0", 2, 0, 16'hABCD, 0);
    check("ror0_ex1", {rec_mode[1], rec_val[1]}, 32'd0);

    issue(0, 2'b11, 4'd9, 16'hBEEF);
    wait_rsp("rsv", 2, 0, 16'hBEEF, 1);

    issue(1, 2'b00, 4'd15, 16'h0001);
    wait_rsp("after_rsv", 2, 1, 16'h8000, 0);

    issue(0, 2'b01, 4'd4, 16'h7FF0);
    wait_rsp("sra_pos", 2, 0, 16'h07FF, 0);

    // Pointer now favours req1. A req1 valid that drops before the edge must
    // not be granted nor move the pointer.
    @(negedge clk);
    req1_valid = 1'b1;
    #1;
    check("pulse_ready1", 32'(req1_ready), 32'd1);
    req1_valid = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b00; req0_amt = 4'd1; req0_data = 16'h0003;
    req1_valid = 1'b1; req1_op = 2'b00; req1_amt = 4'd2; req1_data = 16'h0003;
    #1;
    check("tie_ready", {req0_ready, req1_ready}, 32'b01);
    @(posedge clk);
    #1;
    scramble();
    wait_rsp("tie", 2, 1, 16'h000C, 0);

    // Reset into a fresh pointer, then both requesters hold valid.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_op = 2'b00; req0_amt = 4'd1; req0_data = 16'h0001;
    req1_valid = 1'b1; req1_op = 2'b00; req1_amt = 4'd1; req1_data = 16'h0002;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        g[ng] = req1_ready ? 1 : 0;
        ng++;
      end
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("rr_count", 32'(ng), 32'd4);
    check("rr_order", {g[0][7:0], g[1][7:0], g[2][7:0], g[3][7:0]}, 32'h00010001);
    repeat (4) @(negedge clk);

    // Reset while in EXEC2 of a rotate aborts it silently.
    issue(0, 2'b10, 4'd4, 16'h1234);
    @(negedge clk);
    @(negedge clk);
    check("ex2_state", 32'(dbg_state), 32'd2);
    rst_n = 1'b0;
    req0_valid = 1'b1;
    #1;
    check("abort_sh", {sh_mode, sh_val, sh_in}, 32'd0);
    check("abort_ready", 32'(req0_ready), 32'd0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) bad = 1;
    end
    req0_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rsp_valid) bad = 1;
    end
    check("abort_no_rsp", 32'(bad), 32'd0);
    check("abort_data", 32'(rsp_data), 32'd0);
    issue(1, 2'b00, 4'd8, 16'h00A5);
    wait_rsp("post_rst", 2, 1, 16'hA500, 0);

    check("no_dual_ready", 32'(dual_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_seq_arb.md
SHIFT_SEQ_ARB -- requirements
Module: shift_seq_arb

Interface
REQ-001 The block SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 The block SHALL have ports: rst_n  input  1  asynchronous active-low reset.
REQ-003 The block SHALL have ports: req0_valid, req1_valid  input  1 each  requester N has an operation pending.
REQ-004 The block SHALL have ports: req0_ready, req1_ready  output  1 each  the block accepts requester N this cycle.
REQ-005 The block SHALL have ports: req0_data, req1_data  input  16 each  operand.
REQ-006 The block SHALL have ports: req0_amt, req1_amt  input  4 each  shift amount 0-15.
REQ-007 The block SHALL have ports: req0_op, req1_op  input  2 each  operation code: 00 SLL, 01 SRA, 10 ROR, 11 reserved.
REQ-008 The block SHALL have ports: sh_in  output  16  operand driven to the shared shift unit.
REQ-009 The block SHALL have ports: sh_val  output  4  shift amount driven to the shared shift unit.
REQ-010 The block SHALL have ports: sh_mode  output  1  shift-unit mode: 0 SLL, 1 SRA.
REQ-011 The block SHALL have ports: sh_out  input  16  combinational result returned by the shift unit.
REQ-012 The block SHALL have ports: rsp_valid  output  1  one-cycle result pulse, with no backpressure.
REQ-013 The block SHALL have ports: rsp_id  output  1  requester index that owns the result.
REQ-014 The block SHALL have ports: rsp_data  output  16  result value.
REQ-015 The block SHALL have ports: rsp_err  output  1  reserved opcode was received.

Function
REQ-016 The FSM SHALL have the states IDLE, EXEC1, EXEC2 and RSP; reqN_ready SHALL be asserted only in IDLE.
REQ-017 In IDLE, a request SHALL be granted by round-robin; with both requesters valid, the requester not granted last SHALL win; the pointer SHALL reset to favour req0.
REQ-018 At most one of req0_ready and req1_ready SHALL be high in any cycle; a handshake occurs when validN and readyN are both high.
REQ-019 On a handshake, the block SHALL latch data, amt, op and id, then move to EXEC1.
REQ-020 SLL and SRA: EXEC1 SHALL drive sh_in=data, sh_val=amt and sh_mode=op[0]; sh_out SHALL be captured into the result register; next state RSP.
REQ-021 ROR with amt=0: EXEC1 SHALL drive sh_val=0, sh_mode=0; the result SHALL equal data; next state RSP.
REQ-022 ROR with amt=n, n!=0: EXEC1 SHALL drive SLL by (16-n) and capture sh_out into tmp; next state EXEC2.
REQ-023 ROR EXEC2 SHALL drive SRA by n; the result SHALL be (sh_out AND ~(16'hFFFF << (16-n))) OR tmp; next state RSP.
REQ-024 Reserved op 11 SHALL execute as SLL with amt=0, so the result equals data, and SHALL set rsp_err for that response.
REQ-025 In RSP, rsp_valid SHALL be 1 and rsp_id, rsp_data and rsp_err SHALL be valid for exactly that cycle; next state IDLE.
REQ-026 Latency SHALL be counted from the handshake edge: SLL/SRA/ROR0/reserved rsp_valid high 2 cycles later; ROR n!=0 rsp_valid high 3 cycles later.
REQ-027 Minimum request spacing SHALL be 3 cycles for SLL/SRA/ROR0/reserved and 4 cycles for ROR n!=0.
REQ-028 Outside EXEC1/EXEC2, sh_in, sh_val and sh_mode SHALL be 0; rsp_data SHALL hold its last value when rsp_valid=0.
REQ-029 Changes to requester inputs after the handshake SHALL NOT affect an in-flight operation.
REQ-030 A requester that deasserts valid before a handshake SHALL NOT be granted, and the round-robin pointer SHALL be unchanged.

Reset
REQ-031 rst_n=0 SHALL, asynchronously: set state=IDLE, ready=0 while in reset, rsp_valid=0, rsp_id=0, rsp_err=0, rsp_data=0, tmp=0, sh_* =0, pointer favouring req0.
REQ-032 Reset during EXEC1, EXEC2 or RSP SHALL abort the operation with no rsp_valid pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-033 req0 SLL data=16'h00F1, amt=4 -> rsp_valid 2 cycles after handshake, rsp_id=0, rsp_data=16'h0F10.
REQ-034 req1 SRA data=16'h8000, amt=15 -> rsp_data=16'hFFFF, rsp_id=1, latency 2.
REQ-035 req0 ROR data=16'h1234, amt=4 -> EXEC1 sh_val=12/sh_mode=0, EXEC2 sh_val=4/sh_mode=1, rsp_data=16'h4123 at latency 3.
REQ-036 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; no cycle has both ready high.
REQ-037 req0 op=11 data=16'hBEEF -> rsp_data=16'hBEEF, rsp_err=1; next normal response has rsp_err=0.
REQ-038 rst_n low during ROR EXEC2 -> no rsp_valid pulse; after release, a new SLL completes normally with latency 2.
